// File: rtl/alu_exec_sequencer.sv
`timescale 1ns/1ps
// alu_exec_sequencer
// Issue/writeback controller wrapped around an external 16-bit ALU.
// One instruction is accepted at a time from IDLE. Its operands come from an
// 8x16 register file in which R0 always reads as zero. The ALU inputs are
// driven from registers, the ALU result and status are captured one cycle
// later, and the result is committed one cycle after that.
// Sequence: IDLE -> EXEC -> WB -> IDLE, so throughput is one instruction per
// three cycles. Writeback always completes before the next operand read,
// which is why no hazard logic is needed.

module alu_exec_sequencer #(
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_ra,
  input  logic [ADDR_W-1:0] instr_rb,
  input  logic              instr_use_imm,
  input  logic [15:0]       instr_imm,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [3:0]        alu_opcode,
  output logic              alu_enable,
  input  logic [15:0]       alu_y,
  input  logic [4:0]        alu_status,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic [4:0]        flags,
  output logic              done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  state_t              state_r;
  state_t              state_s;

  // Decoded per-cycle actions
  logic                accept_s;
  logic                load_we_s;
  logic                wb_we_s;
  logic                capture_s;
  logic                commit_s;

  // Register file and pipeline holding registers
  logic [15:0]         regs_r [REG_COUNT];
  logic [15:0]         result_r;
  logic [4:0]          status_r;
  logic [ADDR_W-1:0]   dest_r;

  // Operand read values (R0 forced to zero)
  logic [15:0]         opa_s;
  logic [15:0]         opb_reg_s;
  logic [15:0]         opb_s;

  // Operand selection for the accept edge; the pre-edge register contents are
  // used, so a preload on the same edge is not visible to this instruction.
  always_comb begin
    opa_s     = 16'h0000;
    opb_reg_s = 16'h0000;
    opb_s     = 16'h0000;
    if (instr_ra == ADDR_ZERO) begin
      opa_s = 16'h0000;
    end else begin
      opa_s = regs_r[instr_ra];
    end
    if (instr_rb == ADDR_ZERO) begin
      opb_reg_s = 16'h0000;
    end else begin
      opb_reg_s = regs_r[instr_rb];
    end
    if (instr_use_imm) begin
      opb_s = instr_imm;
    end else begin
      opb_s = opb_reg_s;
    end
  end

  // Next-state and action decode for the issue/execute/writeback sequence.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    load_we_s = 1'b0;
    wb_we_s   = 1'b0;
    capture_s = 1'b0;
    commit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid) begin
          accept_s = 1'b1;
          state_s  = ST_EXEC;
        end else begin
          accept_s = 1'b0;
          state_s  = ST_IDLE;
        end
        // Preload only while idle; R0 is not writable.
        if (load_en && (load_addr != ADDR_ZERO)) begin
          load_we_s = 1'b1;
        end else begin
          load_we_s = 1'b0;
        end
      end
      ST_EXEC: begin
        capture_s = 1'b1;
        state_s   = ST_WB;
      end
      ST_WB: begin
        commit_s = 1'b1;
        state_s  = ST_IDLE;
        if (dest_r != ADDR_ZERO) begin
          wb_we_s = 1'b1;
        end else begin
          wb_we_s = 1'b0;
        end
      end
      default: begin
        // Illegal encoding: return to a safe idle state without committing.
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Register file: writeback (WB only) and preload (IDLE only) never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else if (wb_we_s) begin
      regs_r[dest_r] <= result_r;
    end else if (load_we_s) begin
      regs_r[load_addr] <= load_data;
    end
  end

  // ALU drive registers: loaded on accept, enable dropped after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= 16'h0000;
      alu_b      <= 16'h0000;
      alu_opcode <= 4'h0;
      alu_enable <= 1'b0;
      dest_r     <= ADDR_ZERO;
    end else if (accept_s) begin
      alu_a      <= opa_s;
      alu_b      <= opb_s;
      alu_opcode <= instr_op;
      alu_enable <= 1'b1;
      dest_r     <= instr_rd;
    end else if (capture_s) begin
      alu_enable <= 1'b0;
    end
  end

  // Capture the ALU result and status while the ALU is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 16'h0000;
      status_r <= 5'b00000;
    end else if (capture_s) begin
      result_r <= alu_y;
      status_r <= alu_status;
    end
  end

  // Persistent flags (updated on every writeback, even to R0) and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 5'b00000;
      done  <= 1'b0;
    end else begin
      done <= commit_s;
      if (commit_s) begin
        flags <= status_r;
      end
    end
  end

  // Handshake status is decoded straight from the state register.
  assign instr_ready = (state_r == ST_IDLE);
  assign busy        = ~instr_ready;

  // Debug read port: combinational view of the register file.
  assign rd_data = (rd_addr == ADDR_ZERO) ? 16'h0000 : regs_r[rd_addr];

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
Multi-cycle issue/writeback controller that sits directly upstream and downstream of the 16-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file. It drives the ALU A/B/opcode/enable inputs, captures Y and status, writes the result back to the destination register and updates a persistent flags register.

Parameters:
REG_COUNT, 8, number of general registers (R0 hardwired to zero)
ADDR_W, 3, register address width (log2 REG_COUNT)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (IDLE)
instr_op  in  4  ALU opcode passed unchanged (0=ADD ... 15=CSL)
instr_rd  in  ADDR_W  destination register
instr_ra  in  ADDR_W  source for ALU A
instr_rb  in  ADDR_W  source for ALU B when instr_use_imm=0
instr_use_imm  in  1  1: ALU B = instr_imm
instr_imm  in  16  immediate operand
load_en  in  1  external register preload strobe
load_addr  in  ADDR_W  preload address
load_data  in  16  preload data
alu_a  out  16  registered ALU operand A
alu_b  out  16  registered ALU operand B
alu_opcode  out  4  registered ALU opcode
alu_enable  out  1  ALU enable
alu_y  in  16  ALU result
alu_status  in  5  ALU flags {parity, overflow, negative, zero, carry}
rd_addr  in  ADDR_W  debug read address
rd_data  out  16  combinational read of R[rd_addr] (0 for R0)
flags  out  5  last committed status
done  out  1  one-cycle pulse on writeback
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registers R0..R7=0; alu_a=alu_b=0, alu_opcode=0, alu_enable=0; flags=0; done=0. Any in-flight instruction is discarded with no writeback and no done.
- FSM: IDLE -> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE. busy=~instr_ready.
- Accept at edge N when IDLE and instr_valid=1:
  - alu_a<=R[ra]
  - alu_b<=use_imm ? imm : R[rb]
  - alu_opcode<=op
  - alu_enable<=1
  - state<=EXEC
- Edge N+1 (EXEC): result_q<=alu_y, status_q<=alu_status, alu_enable<=0, state<=WB.
- Edge N+2 (WB): R[rd]<=result_q (dropped if rd=0), flags<=status_q (always, including rd=0), done<=1, state<=IDLE.
- Timing: done high in cycle N+2..N+3 and cleared at edge N+3. The next instruction can be accepted at edge N+3, so throughput is 1 instruction per 3 cycles.
- No hazards: writeback completes before the next operand read. Back-to-back dependent instructions see updated values.
- instr_* fields are sampled only at the accept edge; changes while busy are ignored. instr_valid held high while busy is not consumed.
- Operand usage: A-only ops (NEG, INC, DEC, MOV, NOT) still load alu_b per rules; the ALU ignores it. Shift ops use alu_b[3:0].
- Preload: load_en is honoured only in IDLE and ignored while busy. Writes to R0 are ignored.
- Preload colliding with an accept on the same edge: load writes; the instruction reads the pre-load value.
- flags hold between writebacks and are never modified by preload.
- rd_data is combinational from the register file and reflects writes after the edge.

Test Plan:
- Preload R1=0x7FFF, R2=0x0001; ADD rd=3 ra=1 rb=2 -> done 2 cycles after accept; R3=0x8000; flags[3:0]=4'b1100 (OV=1, N=1, Z=0, C=0); flags[4] equals ALU parity.
- R1=0x1234; SUB rd=4 ra=1 rb=1 -> R4=0x0000, flags[3:0]=4'b0010. Then LSL rd=5 ra=1 use_imm=1 imm=0x0004 -> R5=0x2340.
- ADD rd=0 ra=1 rb=2 with R1=0x7FFF, R2=0x0001 -> rd_data(0)=0x0000; flags updated to 4'b1100; done pulses.
- instr_valid held high with two INC rd=1 ra=1 from R1=0x00FF -> accepts exactly 3 cycles apart, instr_ready low for 2 cycles each, R1=0x0101, two done pulses.
- Preload R6=0xAAAA during busy -> ignored (R6 unchanged). Preload in IDLE on the same edge as an instruction accepted with ra=6 -> alu_a=old R6, R6=new value afterwards.
- rst_n low during EXEC -> immediately alu_enable=0, busy=0, flags=0, all registers 0. No done after release; next instruction accepted normally.
